toggle_event_receiver: RTL and testbench

Receiving end of the toggle-signalling scheme: consumes a level that flips once per event (the `Q` of a toggle flip-flop, possibly from another clock domain or a raw board input) and turns each flip into a one-cycle pulse. It keeps a running event count and queues undelivered events behind a 4-phase req/ack handshake, so downstream logic sees one handshake per toggle. It sits between any toggle source and the consumer that must not miss events.

---
 rtl/toggle_event_receiver.sv | 133 +++++++++++++
 tb/tb_toggle_event_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_receiver.sv
// Toggle-signalling receiver: turns each level change on t_in into a one-cycle pulse,
// counts events, and queues them for delivery over a 4-phase req/ack handshake.
module toggle_event_receiver #(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              t_in,
    output logic              event_pulse,
    output logic [CNT_W-1:0]  event_count,
    output logic              req,
    input  logic              ack,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic              s1;
    logic              s2;
    logic              prev;
    logic [1:0]        arm_cnt;
    logic              armed;
    logic              raw_edge;
    logic              event_det;
    logic              ack_accept;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [PEND_W-1:0] pend_next;
    logic              overflow_next;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is
    // what turns these three statements into a shift chain rather than one wire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= t_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Edges are ignored until the chain has flushed whatever level t_in held through reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= 2'd0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed      = (arm_cnt == 2'd3);
    assign raw_edge   = s2 ^ prev;
    assign event_det  = raw_edge & armed;
    assign ack_accept = (state == ST_REQ) & ack;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // otherwise synthesis infers a latch.
    always_comb begin
        pend_next     = pend_count;
        overflow_next = overflow;
        case ({event_det, ack_accept})
            2'b10: begin
                if (&pend_count) begin
                    overflow_next = 1'b1;
                end else begin
                    pend_next = pend_count + PEND_ONE;
                end
            end
            2'b01:   pend_next = pend_count - PEND_ONE;
            default: pend_next = pend_count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pend_count != '0) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_next = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (!ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // req is decoded from the next state so it leaves a flop with no path from ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            req   <= 1'b0;
        end else begin
            state <= state_next;
            req   <= (state_next == ST_REQ);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            event_pulse <= 1'b0;
            event_count <= '0;
            pend_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            event_pulse <= event_det;
            if (event_det) begin
                event_count <= event_count + CNT_ONE;
            end
            pend_count <= pend_next;
            overflow   <= overflow_next;
        end
    end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: a per-cycle vector table for reset, arming and
// handshake timing, then sequences for saturation, async reset and counter wrap.
module tb_toggle_event_receiver;

    localparam int CNT_W  = 8;
    localparam int PEND_W = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              t_in;
    logic              ack;
    logic              event_pulse;
    logic [CNT_W-1:0]  event_count;
    logic              req;
    logic [PEND_W-1:0] pend_count;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    int handshakes;
    logic prev_req;
    bit auto_ack;

    typedef struct {
        logic              rst_n;
        logic              t;
        logic              a;
        logic              pulse;
        logic [CNT_W-1:0]  cnt;
        logic              rq;
        logic [PEND_W-1:0] pend;
        logic              ovf;
    } vec_t;

    vec_t vq[$];

    toggle_event_receiver #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .t_in        (t_in),
        .event_pulse (event_pulse),
        .event_count (event_count),
        .req         (req),
        .ack         (ack),
        .pend_count  (pend_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: consumer model (if enabled) answers req, then sample #1 after the edge.
    task automatic tick();
        if (auto_ack) ack = req;
        @(posedge clock);
        #1;
        if (prev_req && !req) handshakes++;
        prev_req = req;
    endtask

    task automatic add_vec(input logic r, input logic t, input logic a, input logic p,
                           input logic [CNT_W-1:0] c, input logic q,
                           input logic [PEND_W-1:0] pd, input logic o);
        vq.push_back('{r, t, a, p, c, q, pd, o});
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".pulse"}, 32'(event_pulse), 32'(v.pulse));
        check({tag, ".count"}, 32'(event_count), 32'(v.cnt));
        check({tag, ".req"},   32'(req),         32'(v.rq));
        check({tag, ".pend"},  32'(pend_count),  32'(v.pend));
        check({tag, ".ovf"},   32'(overflow),    32'(v.ovf));
    endtask

    task automatic do_reset(input logic t);
        reset_n = 1'b0;
        t_in    = t;
        ack     = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        t_in       = 1'b1;
        ack        = 1'b0;
        auto_ack   = 1'b0;
        handshakes = 0;
        prev_req   = 1'b0;

        // rst, t_in, ack | pulse, count, req, pend, ovf  (inputs before the edge, outputs after)
        // t_in held high through reset: the arm mask hides the apparent edge.
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        // Fresh reset with t_in low, arm, then a single 0->1 at edge k (v16).
        add_vec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);  // k
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);  // k+1
        add_vec(1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 4'd1, 1'b0);  // k+2 pulse, count, pend
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 4'd1, 1'b0);  // k+3 req rises
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 4'd0, 1'b0);  // ack accepted
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 4'd0, 1'b0);  // WAIT_LOW holds
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 4'd0, 1'b0);  // back to IDLE
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 4'd0, 1'b0);
        // Two toggles 2 cycles apart; the second event lands on the ack-accept edge.
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 4'd0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 4'd0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 4'd1, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 4'd1, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 4'd1, 1'b0);  // +1 and -1 net zero
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 4'd1, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 4'd1, 1'b0);  // WAIT_LOW -> IDLE
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 4'd1, 1'b0);  // new req
        add_vec(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 4'd0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 4'd0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 4'd0, 1'b0);

        foreach (vq[i]) begin
            reset_n = vq[i].rst_n;
            t_in    = vq[i].t;
            ack     = vq[i].a;
            tick();
            check_vec($sformatf("v%0d", i), vq[i]);
        end

        // Saturation: 20 toggles 3 cycles apart, consumer never acks.
        do_reset(1'b1);
        check("sat_start.count", 32'(event_count), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            t_in = ~t_in;
            repeat (3) tick();
            if (i == 15) begin
                check("sat15.pend", 32'(pend_count), 32'd15);
                check("sat15.ovf",  32'(overflow),   32'd0);
            end
            if (i == 16) begin
                check("sat16.pend",  32'(pend_count),  32'd15);
                check("sat16.ovf",   32'(overflow),    32'd1);
                check("sat16.count", 32'(event_count), 32'd16);
            end
        end
        repeat (3) tick();
        check("sat_end.pend",  32'(pend_count),  32'd15);
        check("sat_end.ovf",   32'(overflow),    32'd1);
        check("sat_end.count", 32'(event_count), 32'd20);
        check("sat_end.req",   32'(req),         32'd1);

        // Asynchronous reset in the middle of a handshake with three events pending.
        do_reset(t_in);
        for (int i = 0; i < 3; i++) begin
            t_in = ~t_in;
            repeat (3) tick();
        end
        check("pre_rst.pend",  32'(pend_count),  32'd3);
        check("pre_rst.req",   32'(req),         32'd1);
        check("pre_rst.count", 32'(event_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.req",   32'(req),         32'd0);
        check("async_rst.pend",  32'(pend_count),  32'd0);
        check("async_rst.count", 32'(event_count), 32'd0);
        check("async_rst.pulse", 32'(event_pulse), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();

        // 256 events with a prompt consumer: counter wraps, every event gets a handshake.
        handshakes = 0;
        prev_req   = req;
        auto_ack   = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            t_in = ~t_in;
            repeat (4) tick();
            if (i == 255) check("wrap255.count", 32'(event_count), 32'd255);
        end
        for (int w = 0; w < 64 && (pend_count != '0 || req || ack); w++) tick();
        repeat (2) tick();
        check("wrap.count",      32'(event_count), 32'd0);
        check("wrap.handshakes", 32'(handshakes),  32'd256);
        check("wrap.ovf",        32'(overflow),    32'd0);
        check("wrap.pend",       32'(pend_count),  32'd0);
        check("wrap.req",        32'(req),         32'd0);
        auto_ack = 1'b0;
        ack      = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
